leglite_single_core: RTL and testbench

- 16-bit single-cycle LEGLite processor core. Every instruction fetches, decodes, executes and writes back in one clock cycle.
- Sits between an external combinational instruction ROM (idata/iaddr) and an external data-memory/IO block (draddr/dwdata/drdata with dwrite/dread strobes).
- Exposes its ALU result for debug.

---
 rtl/leglite_single_core.sv | 124 ++++++++++++
 tb/tb_leglite_single_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/leglite_single_core.sv
// leglite_single_core: 16-bit single-cycle LEGLite core.
// Fetch, decode, execute and writeback all complete in one clock cycle.
// The instruction ROM and the data memory are external and combinational.
// X7 is the zero register (XZR). It always reads 0, and writes to it are dropped.
module leglite_single_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  output logic [15:0] draddr,
  output logic        dwrite,
  output logic        dread,
  output logic [15:0] dwdata,
  input  logic [15:0] drdata,
  output logic [15:0] alu_out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LDUR = 4'd5;
  localparam logic [3:0] OP_STUR = 4'd6;
  localparam logic [3:0] OP_CBZ  = 4'd7;
  localparam logic [3:0] OP_B    = 4'd8;

  logic [15:0] pc_q, pc_d;
  logic [15:0] regs_q [0:7];
  logic [15:0] regs_d [0:7];

  logic [3:0]  op;
  logic [2:0]  rn, rm, rt;
  logic [5:0]  imm6;
  logic [8:0]  off9;
  logic [11:0] off12;

  logic [15:0] rn_val, rm_val, rt_val;
  logic [15:0] alu_res;
  logic        rf_we;
  logic [15:0] rf_wdata;

  // Slice the instruction word into its fields.
  always_comb begin
    op    = idata[15:12];
    rn    = idata[11:9];
    rm    = idata[8:6];
    rt    = idata[2:0];
    imm6  = idata[8:3];
    off9  = idata[11:3];
    off12 = idata[11:0];
  end

  // Register reads. The X7 entry is never written, so it always reads 0.
  // rt has its own port because dwdata must show R[rt] on every instruction.
  always_comb begin
    rn_val = regs_q[rn];
    rm_val = regs_q[rm];
    rt_val = regs_q[rt];
  end

  // ALU: select the result, the writeback data and the write enable by opcode.
  always_comb begin
    alu_res  = 16'h0000;
    rf_we    = 1'b0;
    rf_wdata = 16'h0000;
    case (op)
      OP_ADD:  begin alu_res = rn_val + rm_val; rf_we = 1'b1; rf_wdata = alu_res; end
      OP_SUB:  begin alu_res = rn_val - rm_val; rf_we = 1'b1; rf_wdata = alu_res; end
      OP_AND:  begin alu_res = rn_val & rm_val; rf_we = 1'b1; rf_wdata = alu_res; end
      OP_ORR:  begin alu_res = rn_val | rm_val; rf_we = 1'b1; rf_wdata = alu_res; end
      OP_ADDI: begin
        alu_res  = rn_val + {10'b0, imm6};
        rf_we    = 1'b1;
        rf_wdata = alu_res;
      end
      OP_LDUR: begin
        alu_res  = rn_val + {{10{imm6[5]}}, imm6};
        rf_we    = 1'b1;
        rf_wdata = drdata;
      end
      OP_STUR: alu_res = rn_val + {{10{imm6[5]}}, imm6};
      OP_CBZ:  alu_res = rt_val;
      default: alu_res = 16'h0000;
    endcase
  end

  // Next PC. A taken CBZ or a B adds the doubled signed offset; otherwise PC advances by 2.
  always_comb begin
    pc_d = pc_q + 16'd2;
    if (op == OP_CBZ && alu_res == 16'h0000)
      pc_d = pc_q + {{6{off9[8]}}, off9, 1'b0};
    else if (op == OP_B)
      pc_d = pc_q + {{3{off12[11]}}, off12, 1'b0};
  end

  // Register-file write. Entry 7 is pinned at zero so XZR discards writes.
  always_comb begin
    for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
    if (rf_we) regs_d[rt] = rf_wdata;
    regs_d[7] = 16'h0000;
  end

  // State update. Asserting reset aborts the writeback of the in-flight instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign iaddr   = pc_q;
  assign alu_out = alu_res;
  assign draddr  = alu_res;
  assign dwdata  = rt_val;
  assign dread   = (op == OP_LDUR);
  assign dwrite  = (op == OP_STUR);

endmodule

// File: tb/tb_leglite_single_core.sv
// Directed testbench for leglite_single_core. The expected values are hand-computed.
// A register is observed with a NOP whose rt field names it, because dwdata always equals R[rt].
module tb_leglite_single_core;

  logic        clock;
  logic        reset;
  logic [15:0] iaddr, idata, draddr, dwdata, drdata, alu_out;
  logic        dwrite, dread;

  int checks = 0;
  int errors = 0;

  leglite_single_core #(.RESET_PC(16'h0000)) dut (
    .clock  (clock),
    .reset  (reset),
    .iaddr  (iaddr),
    .idata  (idata),
    .draddr (draddr),
    .dwrite (dwrite),
    .dread  (dread),
    .dwdata (dwdata),
    .drdata (drdata),
    .alu_out(alu_out)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // encoders
  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rn,
                                        input logic [2:0] rm, input logic [2:0] rd);
    return {op, rn, rm, 3'b000, rd};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rn,
                                        input logic [5:0] imm, input logic [2:0] rt);
    return {op, rn, imm, rt};
  endfunction

  function automatic logic [15:0] enc_cbz(input logic [8:0] off, input logic [2:0] rt);
    return {4'h7, off, rt};
  endfunction

  function automatic logic [15:0] enc_b(input logic [11:0] off);
    return {4'h8, off};
  endfunction

  // checker
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr);
    idata = instr;
    #1;
  endtask

  task automatic peek(input logic [2:0] r, input logic [15:0] exp, input string tag);
    drive({4'h9, 9'b0, r});
    check(tag, dwdata, exp);
  endtask

  initial begin
    reset  = 1'b0;
    idata  = 16'h9000;
    drdata = 16'h0000;

    // Reset held for two cycles.
    repeat (2) @(posedge clock);
    #1;
    check("rst_iaddr", iaddr, 16'h0000);
    check("rst_dwrite", {15'b0, dwrite}, 16'h0000);
    check("rst_dread", {15'b0, dread}, 16'h0000);
    for (int r = 0; r < 8; r++) peek(r[2:0], 16'h0000, "rst_reg");

    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rel_iaddr", iaddr, 16'h0000);

    // ADDI X4,XZR,#3
    drive(16'h4E1C);
    check("addi_alu", alu_out, 16'd3);
    check("addi_draddr", draddr, 16'd3);
    check("addi_dwrite", {15'b0, dwrite}, 16'h0000);
    step();
    check("addi_pc", iaddr, 16'd2);

    // ADDI X4,X4,#3 reads the old X4.
    drive(enc_i(4'h4, 3'd4, 6'd3, 3'd4));
    check("addi2_alu", alu_out, 16'd6);
    step();
    peek(3'd4, 16'd6, "x4_val");

    drive(enc_i(4'h4, 3'd7, 6'd5, 3'd1)); step();
    drive(enc_i(4'h4, 3'd7, 6'd3, 3'd2)); step();
    check("pc_8", iaddr, 16'd8);

    // ALU ops on X1=5 and X2=3
    drive(enc_r(4'h0, 3'd1, 3'd2, 3'd3)); check("add", alu_out, 16'd8); step();
    peek(3'd3, 16'd8, "add_wb");
    drive(enc_r(4'h1, 3'd1, 3'd2, 3'd3)); check("sub", alu_out, 16'd2); step();
    drive(enc_r(4'h2, 3'd1, 3'd2, 3'd3)); check("and", alu_out, 16'd1); step();
    drive(enc_r(4'h3, 3'd1, 3'd2, 3'd3)); check("orr", alu_out, 16'd7); step();
    peek(3'd3, 16'd7, "orr_wb");
    drive(enc_r(4'h1, 3'd2, 3'd1, 3'd3)); check("sub_wrap", alu_out, 16'hFFFE); step();
    peek(3'd3, 16'hFFFE, "sub_wrap_wb");
    drive(enc_r(4'h0, 3'd1, 3'd2, 3'd7)); check("add_xzr", alu_out, 16'd8); step();
    peek(3'd7, 16'h0000, "xzr_wb");

    // STUR X4,[XZR,#4]
    drive(enc_i(4'h6, 3'd7, 6'd4, 3'd4));
    check("stur_dwrite", {15'b0, dwrite}, 16'd1);
    check("stur_dread", {15'b0, dread}, 16'd0);
    check("stur_draddr", draddr, 16'd4);
    check("stur_dwdata", dwdata, 16'd6);
    step();

    // LDUR X5,[XZR,#4]
    drdata = 16'd6;
    drive(enc_i(4'h5, 3'd7, 6'd4, 3'd5));
    check("ldur_dread", {15'b0, dread}, 16'd1);
    check("ldur_dwrite", {15'b0, dwrite}, 16'd0);
    check("ldur_draddr", draddr, 16'd4);
    step();
    drdata = 16'h0000;
    peek(3'd5, 16'd6, "ldur_wb");
    check("pc_24", iaddr, 16'd24);

    // LDUR with a negative offset: X4 + sext(-2) = 4
    drive(enc_i(4'h5, 3'd4, 6'h3E, 3'd6));
    check("ldur_neg_addr", draddr, 16'd4);

    // Asynchronous reset between edges while ADDI X6 is in flight.
    drive(enc_i(4'h4, 3'd7, 6'd7, 3'd6));
    #2;
    reset = 1'b0;
    #1;
    check("async_pc", iaddr, 16'h0000);
    @(posedge clock);
    #1;
    peek(3'd6, 16'h0000, "abort_x6");
    peek(3'd4, 16'h0000, "rst_x4");
    peek(3'd5, 16'h0000, "rst_x5");
    @(negedge clock);
    reset = 1'b1;
    drive(16'h9000);
    check("rel2_iaddr", iaddr, 16'h0000);

    // Branches. X1=1; run NOPs up to PC=10.
    drive(enc_i(4'h4, 3'd7, 6'd1, 3'd1)); step();
    for (int i = 0; i < 4; i++) begin drive(16'hF000); step(); end
    check("pc_10", iaddr, 16'd10);
    drive(enc_cbz(9'h1FE, 3'd0));
    check("cbz_alu", alu_out, 16'd0);
    step();
    check("cbz_taken", iaddr, 16'd6);
    drive(enc_b(12'd4)); check("b_alu", alu_out, 16'd0); step();
    check("b_fwd", iaddr, 16'd14);
    drive(enc_b(12'hFFE)); step();
    check("b_back", iaddr, 16'd10);
    drive(enc_cbz(9'h1FE, 3'd1));
    check("cbz_nz_alu", alu_out, 16'd1);
    step();
    check("cbz_not_taken", iaddr, 16'd12);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
